regfile_writeback_queue: RTL

Write-side initiator for the 32x32 register file. Accepts register write requests from two producers, ALU results and memory load results. Each producer uses a valid/ready handshake. Requests are buffered in a small in-order FIFO and drained at one write per cycle onto the register file's rd/busW/writeEnable port. The block also reports whether a queried rs/rt has a write still pending, so issue logic can stall.

---
 rtl/regfile_writeback_queue.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - two-producer in-order write queue draining onto the register file write port
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           alu_valid,
    input  logic [0:4]     alu_rd,
    input  logic [0:31]    alu_data,
    output logic           alu_ready,
    input  logic           mem_valid,
    input  logic [0:4]     mem_rd,
    input  logic [0:31]    mem_data,
    output logic           mem_ready,
    output logic [0:4]     rd,
    output logic [0:31]    busW,
    output logic           writeEnable,
    input  logic [0:4]     query_rs,
    input  logic [0:4]     query_rt,
    output logic           pending_rs,
    output logic           pending_rt,
    output logic [0:PTR_W] count
);

    localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(DEPTH);

    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W+1:0] free;
    logic             drain;
    logic             alu_acc;
    logic             alu_enq;
    logic             mem_enq;
    logic [PTR_W-1:0] mem_slot;
    logic [PTR_W-1:0] slot;

    // The head slot drains every cycle the queue is nonempty, so it counts as free.
    always_comb begin
        drain     = (count_q != '0);
        free      = DEPTH_C - {1'b0, count_q} + (PTR_W+2)'(drain);
        alu_ready = (free >= (PTR_W+2)'(1));
        alu_acc   = alu_valid & alu_ready;
        mem_ready = (free >= ((PTR_W+2)'(1) + (PTR_W+2)'(alu_acc)));
        alu_enq   = alu_acc && (alu_rd != 5'd0);
        mem_enq   = mem_valid && mem_ready && (mem_rd != 5'd0);
        mem_slot  = tail_q + PTR_W'(alu_enq);
        head_d    = head_q + PTR_W'(drain);
        tail_d    = tail_q + PTR_W'(alu_enq) + PTR_W'(mem_enq);
        count_d   = count_q + (PTR_W+1)'(alu_enq) + (PTR_W+1)'(mem_enq) - (PTR_W+1)'(drain);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (alu_enq) begin
                rd_q[tail_q]   <= alu_rd;
                data_q[tail_q] <= alu_data;
            end
            if (mem_enq) begin
                rd_q[mem_slot]   <= mem_rd;
                data_q[mem_slot] <= mem_data;
            end
        end
    end

    always_comb begin
        writeEnable = drain;
        rd          = drain ? rd_q[head_q] : 5'd0;
        busW        = drain ? data_q[head_q] : 32'd0;
        count       = count_q;
    end

    // Scan occupied slots starting at head; same-cycle accepts are not yet visible.
    always_comb begin
        pending_rs = 1'b0;
        pending_rt = 1'b0;
        slot       = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            if ((PTR_W+1)'(k) < count_q) begin
                if ((query_rs != 5'd0) && (rd_q[slot] == query_rs)) pending_rs = 1'b1;
                if ((query_rt != 5'd0) && (rd_q[slot] == query_rt)) pending_rt = 1'b1;
            end
        end
    end

endmodule
